// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command byte handshake and per-byte status between system and PS/2 transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, ack_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, ack_err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device byte transmitter driving open-drain pads via low-active enables.
// Define PS2_TX_TIMEOUT_EN to add a device-clock watchdog; without it a silent device keeps the block busy.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe,
  ps2_host_tx_if.slave tx
);
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_DATA      = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  localparam int IW = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
  // Clock is held low for INHIBIT_CYCLES: INHIBIT-1 cycles here plus the first START cycle.
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 2);

  logic [2:0]    state;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [3:0]    bit_cnt;
  logic [3:0]    cnt_inc;
  logic [IW-1:0] inh_cnt;
  logic          clk_oe_r;
  logic          data_oe_r;
  logic          done_r;
  logic          ack_res;
  logic          ack_err_r;
  logic          clk_s1, clk_s2, clk_d;
  logic          data_s1, data_s2;
  logic          fall;
  logic          tx_ready_w;

`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [19:0] WD_LAST = 20'(TIMEOUT_CYCLES - 1);
  logic [19:0] wdog;
  logic [2:0]  state_d;
  logic        watched;
  assign watched = (state != ST_IDLE) && (state != ST_INHIBIT);
`endif

  assign fall       = clk_d & ~clk_s2;
  assign cnt_inc    = (bit_cnt == 4'd10) ? 4'd10 : bit_cnt + 4'd1;
  assign tx_ready_w = (state == ST_IDLE) && !done_r;

  assign tx.tx_ready = tx_ready_w;
  assign tx.busy     = ~tx_ready_w;
  assign tx.done     = done_r;
  assign tx.ack_err  = ack_err_r;
  assign ps2_clk_oe  = clk_oe_r;
  assign ps2_data_oe = data_oe_r;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      par_bit   <= 1'b0;
      bit_cnt   <= '0;
      inh_cnt   <= '0;
      clk_oe_r  <= 1'b0;
      data_oe_r <= 1'b0;
      done_r    <= 1'b0;
      ack_res   <= 1'b0;
      ack_err_r <= 1'b0;
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      clk_d     <= 1'b1;
      data_s1   <= 1'b1;
      data_s2   <= 1'b1;
`ifdef PS2_TX_TIMEOUT_EN
      wdog      <= '0;
      state_d   <= ST_IDLE;
`endif
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      clk_d   <= clk_s2;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
      done_r  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (tx.tx_valid && tx_ready_w) begin
            shreg    <= tx.tx_data;
            par_bit  <= ~^tx.tx_data;
            bit_cnt  <= '0;
            inh_cnt  <= '0;
            clk_oe_r <= 1'b1;
            state    <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          inh_cnt <= inh_cnt + 1'b1;
          if (inh_cnt == INH_LAST) begin
            data_oe_r <= 1'b1;
            state     <= ST_START;
          end
        end
        ST_START: begin
          clk_oe_r <= 1'b0;
          if (fall) begin
            bit_cnt   <= cnt_inc;
            data_oe_r <= ~shreg[0];
            shreg     <= {1'b0, shreg[7:1]};
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (fall) begin
            bit_cnt <= cnt_inc;
            if (cnt_inc <= 4'd8) begin
              data_oe_r <= ~shreg[0];
              shreg     <= {1'b0, shreg[7:1]};
            end else if (cnt_inc == 4'd9) begin
              data_oe_r <= ~par_bit;
            end else begin
              data_oe_r <= 1'b0;
              state     <= ST_ACK;
            end
          end
        end
        ST_ACK: begin
          if (fall) begin
            bit_cnt <= cnt_inc;
            ack_res <= data_s2;
            state   <= ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (clk_s2 && data_s2) begin
            done_r    <= 1'b1;
            ack_err_r <= ack_res;
            state     <= ST_IDLE;
          end
        end
        default: begin
          clk_oe_r  <= 1'b0;
          data_oe_r <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      // Placed after the case so an expiring watchdog overrides any normal transition.
      state_d <= state;
      if (fall || (state != state_d))
        wdog <= '0;
      else
        wdog <= wdog + 1'b1;
      if (watched && (wdog == WD_LAST)) begin
        clk_oe_r  <= 1'b0;
        data_oe_r <= 1'b0;
        done_r    <= 1'b1;
        ack_err_r <= 1'b1;
        state     <= ST_IDLE;
      end
`endif
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - randomized bench for ps2_host_tx with a behavioural keyboard and frame model.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INHIB = 100;
  localparam int TMO   = 1000;

  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic pad_clk, pad_data;
  logic ps2_clk_oe, ps2_data_oe;

  ps2_host_tx_if bus();

  assign pad_clk  = dev_clk & ~ps2_clk_oe;
  assign pad_data = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INHIB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk),
    .clrn(clrn),
    .ps2_clk(pad_clk),
    .ps2_data(pad_data),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .tx(bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int run      = 0;
  bit m_busy   = 1'b0;
  bit m_lat    = 1'b0;
  bit exp_ack  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Wire order as the device sees it: start, 8 data bits LSB first, odd parity, stop.
  function automatic logic [10:0] frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!clrn) begin
        m_busy = 1'b0;
        m_lat  = 1'b0;
        run    = 0;
      end else begin
        chk("tx_ready", 32'(bus.tx_ready), 32'(!m_busy));
        chk("busy", 32'(bus.busy), 32'(m_busy));
        if (!m_busy) begin
          chk("idle_clk_oe", 32'(ps2_clk_oe), 0);
          chk("idle_data_oe", 32'(ps2_data_oe), 0);
        end
        if (m_lat) chk("accept_to_clk_oe", 32'(ps2_clk_oe), 1);
        if (ps2_clk_oe) begin
          run++;
        end else if (run != 0) begin
          chk("inhibit_len", 32'(run), 32'(INHIB));
          chk("data_low_at_clk_release", 32'(ps2_data_oe), 1);
          run = 0;
        end
        if (bus.done) begin
          chk("done_in_transfer", 32'(m_busy), 1);
          chk("ack_err", 32'(bus.ack_err), 32'(exp_ack));
          done_cnt++;
        end
        m_lat = 1'b0;
        if (m_busy && bus.done) begin
          m_busy = 1'b0;
        end else if (!m_busy && bus.tx_valid) begin
          m_busy = 1'b1;
          m_lat  = 1'b1;
        end
      end
    end
  end

  task automatic device(input int stop_after, input bit give_ack, input bit inject,
                        output logic [10:0] got, output bit ok);
    int n;
    got = '0;
    ok  = 1'b0;
    n   = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 4 * INHIB) begin
      cyc(1);
      n++;
    end
    chk("request_timeout", 32'(n >= 4 * INHIB), 0);
    if (n >= 4 * INHIB) return;
    cyc(20);
    got[0] = pad_data;
    for (int e = 1; e <= 11; e++) begin
      if (e > stop_after) return;
      if (e == 11) begin
        dev_data = give_ack ? 1'b0 : 1'b1;
        cyc(10);
      end
      dev_clk = 1'b0;
      cyc(40);
      dev_clk = 1'b1;
      if (e <= 10) got[e] = pad_data;
      if (inject && e == 5) begin
        bus.tx_data  = 8'h55;
        bus.tx_valid = 1'b1;
        cyc(2);
        bus.tx_valid = 1'b0;
        cyc(38);
      end else begin
        cyc(40);
      end
    end
    dev_data = 1'b1;
    ok = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input int stop_after, input bit give_ack,
                      input bit inject, output logic [10:0] got);
    int d0, n;
    bit ok;
    exp_ack      = !(give_ack && stop_after >= 11);
    d0           = done_cnt;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    cyc(1);
    bus.tx_valid = 1'b0;
    device(stop_after, give_ack, inject, got, ok);
    if (ok) begin
      chk("frame", 32'(got), 32'(frame(b)));
      n = 0;
      while (done_cnt == d0 && n < 200) begin
        cyc(1);
        n++;
      end
      chk("done_count", 32'(done_cnt), 32'(d0 + 1));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] got;
    logic [7:0]  b;
    bit          a, inj;
    int          exp_done, d0, n;
    exp_done     = 0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    clrn         = 1'b0;
    #12;
    chk("rst_clk_oe", 32'(ps2_clk_oe), 0);
    chk("rst_data_oe", 32'(ps2_data_oe), 0);
    chk("rst_tx_ready", 32'(bus.tx_ready), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_ack_err", 32'(bus.ack_err), 0);
    @(posedge clk);
    #1;
    clrn = 1'b1;
    cyc(3);

    send(8'hED, 11, 1'b1, 1'b0, got); exp_done++;
    chk("ed_wire", 32'(got), 32'h7DA);
    chk("ed_ack_err", 32'(bus.ack_err), 0);

    send(8'h01, 11, 1'b1, 1'b0, got); exp_done++;
    chk("par_01", 32'(got[9]), 0);
    send(8'hFF, 11, 1'b1, 1'b0, got); exp_done++;
    chk("par_ff", 32'(got[9]), 1);

    send(8'($urandom_range(0, 255)), 11, 1'b0, 1'b0, got); exp_done++;
    cyc(1);
    chk("noack_ack_err", 32'(bus.ack_err), 1);
    chk("noack_clk_oe", 32'(ps2_clk_oe), 0);
    chk("noack_data_oe", 32'(ps2_data_oe), 0);

    send(8'hA3, 11, 1'b1, 1'b1, got); exp_done++;
    send(8'($urandom_range(0, 255)), 11, 1'b1, 1'b0, got); exp_done++;

    for (int i = 0; i < 5; i++) begin
      b   = 8'($urandom_range(0, 255));
      a   = 1'($urandom_range(0, 1));
      inj = 1'($urandom_range(0, 1));
      send(b, 11, a, inj, got); exp_done++;
    end

`ifdef PS2_TX_TIMEOUT_EN
    d0 = done_cnt;
    send(8'($urandom_range(0, 255)), 4, 1'b1, 1'b0, got); exp_done++;
    n = 0;
    while (done_cnt == d0 && n < TMO + 3) begin
      cyc(1);
      n++;
    end
    chk("timeout_done", 32'(done_cnt), 32'(d0 + 1));
    cyc(1);
    chk("timeout_clk_oe", 32'(ps2_clk_oe), 0);
    chk("timeout_data_oe", 32'(ps2_data_oe), 0);
    chk("timeout_ack_err", 32'(bus.ack_err), 1);
`endif

    // 0xE0 has bit 4 clear, so the data line is pulled low after the fifth edge.
    d0 = done_cnt;
    send(8'hE0, 5, 1'b1, 1'b0, got);
    chk("pre_reset_data_oe", 32'(ps2_data_oe), 1);
    chk("pre_reset_busy", 32'(bus.busy), 1);
    #2;
    clrn = 1'b0;
    #1;
    chk("async_rst_clk_oe", 32'(ps2_clk_oe), 0);
    chk("async_rst_data_oe", 32'(ps2_data_oe), 0);
    cyc(3);
    clrn = 1'b1;
    cyc(1);
    chk("post_rst_tx_ready", 32'(bus.tx_ready), 1);
    chk("post_rst_no_done", 32'(done_cnt), 32'(d0));

    send(8'hF4, 11, 1'b1, 1'b0, got); exp_done++;
    chk("f4_ack_err", 32'(bus.ack_err), 0);

    cyc(5);
    chk("total_done", 32'(done_cnt), 32'(exp_done));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
